// File: rtl/mips_wbslave_mem_pkg.sv
// Shared Wishbone widths and parameter limits for the pipelined RAM responder.
package mips_wbslave_mem_pkg;

  localparam int WB_ADR_W = 30;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam int LATENCY_MIN   = 1;
  localparam int LATENCY_MAX   = 4;
  localparam int MAX_OUTST_MIN = 1;

  typedef logic [WB_DAT_W-1:0] wb_data_t;

  // One request per delay stage plus the slot an ack frees in its own cycle.
  function automatic int max_outst_limit(input int latency);
    return latency + 1;
  endfunction

  function automatic bit params_ok(input int latency, input int max_outst);
    return (latency >= LATENCY_MIN) && (latency <= LATENCY_MAX) &&
           (max_outst >= MAX_OUTST_MIN) && (max_outst <= max_outst_limit(latency));
  endfunction

endpackage

// File: rtl/mips_wbslave_delay.sv
// Response delay line: DEPTH-stage shift register of {valid, we, data};
// flush drops every in-flight valid bit on the next edge.
module mips_wbslave_delay #(
  parameter int DEPTH = 1,
  parameter int DAT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             we_i,
  input  logic [DAT_W-1:0] dat_i,
  output logic             valid_o,
  output logic             we_o,
  output logic [DAT_W-1:0] dat_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] we_q, we_d;
  logic [DAT_W-1:0] dat_q [DEPTH];
  logic [DAT_W-1:0] dat_d [DEPTH];

  // Next-state: flush clears validity only; payload keeps shifting.
  always_comb begin
    we_d     = we_q;
    dat_d    = dat_q;
    valid_d  = '0;
    we_d[0]  = we_i;
    dat_d[0] = dat_i;
    for (int i = 1; i < DEPTH; i++) begin
      we_d[i]  = we_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    if (flush_i) begin
      valid_d = '0;
    end else begin
      valid_d[0] = load_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      we_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign we_o    = we_q[DEPTH-1];
  assign dat_o   = dat_q[DEPTH-1];

endmodule

// File: rtl/mips_wbslave_mem.sv
// Wishbone pipelined responder in front of a word-addressed RAM with byte-lane
// writes, fixed-latency in-order acks and a bounded outstanding window.
module mips_wbslave_mem
  import mips_wbslave_mem_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 1,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [WB_ADR_W-1:0] wb_adr_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                stall_inject_i,
  output logic                wb_stall_o,
  output logic                wb_ack_o,
  output logic [WB_DAT_W-1:0] wb_dat_o
);

  if (!params_ok(LATENCY, MAX_OUTST)) begin : g_bad_params
    $error("mips_wbslave_mem: LATENCY/MAX_OUTST outside legal range");
  end

  localparam int                 OUTST_W    = $clog2(MAX_OUTST + 1);
  localparam logic [OUTST_W-1:0] OUTST_FULL = OUTST_W'(MAX_OUTST);

  wb_data_t             mem_q [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] idx_s;
  wb_data_t             rd_word_s;
  logic                 accept_s;
  logic                 ack_s;
  logic                 last_valid_s;
  logic                 last_we_s;
  wb_data_t             last_dat_s;
  logic [OUTST_W-1:0]   outst_q, outst_d;
  logic                 unused_adr_s;

  // High address bits are dropped, so the RAM aliases across the address space.
  assign idx_s        = wb_adr_i[ADDR_BITS-1:0];
  assign unused_adr_s = ^wb_adr_i[WB_ADR_W-1:ADDR_BITS];
  assign rd_word_s    = mem_q[idx_s];

  // Bus handshake; a dropped cycle masks any ack leaving the delay line.
  always_comb begin
    ack_s      = last_valid_s & wb_cyc_i;
    wb_ack_o   = ack_s;
    wb_dat_o   = (ack_s && !last_we_s) ? last_dat_s : 32'd0;
    wb_stall_o = stall_inject_i | ((outst_q == OUTST_FULL) & ~ack_s);
    accept_s   = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  end

  // Outstanding count; accept and ack in one cycle cancel out.
  always_comb begin
    outst_d = outst_q;
    if (!wb_cyc_i) begin
      outst_d = '0;
    end else if (accept_s && !ack_s) begin
      outst_d = outst_q + OUTST_W'(1);
    end else if (ack_s && !accept_s) begin
      outst_d = outst_q - OUTST_W'(1);
    end else begin
      outst_d = outst_q;
    end
  end

  // Outstanding counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end

  // RAM keeps its contents across reset; byte lanes commit on the accept edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WB_SEL_W; i++) begin
      if (accept_s && wb_we_i && wb_sel_i[i]) begin
        mem_q[idx_s][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  mips_wbslave_delay #(
    .DEPTH (LATENCY),
    .DAT_W (WB_DAT_W)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (~wb_cyc_i),
    .load_i  (accept_s),
    .we_i    (wb_we_i),
    .dat_i   (rd_word_s),
    .valid_o (last_valid_s),
    .we_o    (last_we_s),
    .dat_o   (last_dat_s)
  );

endmodule

// File: tb/tb_mips_wbslave_mem.sv
// Self-checking bench: a queue-of-due-times reference model checked every cycle,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_mips_wbslave_mem;

  localparam int LAT = 3;
  localparam int MAX = 2;
  localparam int AB  = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, inj;
  logic [29:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat;
  logic        stall_o, ack_o;
  logic [31:0] dat_o;

  always #5 clk = ~clk;

  mips_wbslave_mem #(.ADDR_BITS(AB), .LATENCY(LAT), .MAX_OUTST(MAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_cyc_i       (cyc),
    .wb_stb_i       (stb),
    .wb_we_i        (we),
    .wb_adr_i       (adr),
    .wb_sel_i       (sel),
    .wb_dat_i       (dat),
    .stall_inject_i (inj),
    .wb_stall_o     (stall_o),
    .wb_ack_o       (ack_o),
    .wb_dat_o       (dat_o)
  );

  typedef struct {
    int          due;
    logic        we;
    logic [31:0] data;
  } rsp_t;

  rsp_t        pend[$];
  logic [31:0] mdl_mem [0:4095];
  int          acc_log[$];
  int          ack_log[$];
  logic [31:0] rd_log[$];
  int          cyc_n = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic int acc_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return -1;
  endfunction

  function automatic int ack_at(input int i);
    if (i < ack_log.size()) return ack_log[i];
    return -1;
  endfunction

  function automatic logic [31:0] rd_at(input int i);
    if (i < rd_log.size()) return rd_log[i];
    return 32'h0BAD_0BAD;
  endfunction

  // Reference model and per-cycle compare, evaluated mid-cycle on the falling edge.
  initial begin
    logic        e_ack, e_stall;
    logic [31:0] e_dat;
    int          idx;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend.delete();
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_stall", 32'(stall_o), 32'(inj));
      end else begin
        e_ack = 1'b0;
        e_dat = 32'd0;
        if (cyc && pend.size() > 0) e_ack = (pend[0].due == cyc_n);
        if (e_ack && !pend[0].we) e_dat = pend[0].data;
        e_stall = inj || (pend.size() == MAX && !e_ack);
        check("ack", 32'(ack_o), 32'(e_ack));
        check("dat", dat_o, e_dat);
        check("stall", 32'(stall_o), 32'(e_stall));
        check("outst", 32'(dut.outst_q), 32'(pend.size()));
        if (ack_o) ack_log.push_back(cyc_n);
        if (cyc && stb && !stall_o) acc_log.push_back(cyc_n);
        if (e_ack) begin
          if (ack_o && !pend[0].we) rd_log.push_back(dat_o);
          void'(pend.pop_front());
        end
        if (!cyc) pend.delete();
        if (cyc && stb && !e_stall) begin
          idx = int'(adr[AB-1:0]);
          pend.push_back('{due: cyc_n + LAT, we: we, data: mdl_mem[idx]});
          if (we) begin
            for (int b = 0; b < 4; b++) begin
              if (sel[b]) mdl_mem[idx][8*b +: 8] = dat[8*b +: 8];
            end
          end
        end
      end
      cyc_n++;
    end
  end

  task automatic req(input logic w, input logic [29:0] a, input logic [3:0] s, input logic [31:0] d);
    logic done;
    done = 1'b0;
    stb  = 1'b1;
    we   = w;
    adr  = a;
    sel  = s;
    dat  = d;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      done = !stall_o;
      @(posedge clk);
      #1;
    end
    stb = 1'b0;
    check("req_accepted", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    stb = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int br, ba, bk, rel;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; inj = 1'b0;
    adr = 30'd0; sel = 4'd0; dat = 32'd0;
    repeat (2) @(posedge clk);
    #1 inj = 1'b1;
    @(posedge clk);
    #1 inj = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1 cyc = 1'b1;

    // Back-to-back writes then reads.
    br = rd_log.size();
    req(1'b1, 30'h10, 4'hF, 32'hDEADBEEF);
    req(1'b1, 30'h11, 4'hF, 32'h12345678);
    req(1'b0, 30'h10, 4'h0, 32'd0);
    req(1'b0, 30'h11, 4'h0, 32'd0);
    idle(LAT + 2);
    check("b2b_rd_count", 32'(rd_log.size() - br), 32'd2);
    check("b2b_rd0", rd_at(br), 32'hDEADBEEF);
    check("b2b_rd1", rd_at(br + 1), 32'h12345678);

    // Byte lanes.
    br = rd_log.size();
    req(1'b1, 30'h5, 4'hF, 32'hAABBCCDD);
    req(1'b1, 30'h5, 4'b0101, 32'h11223344);
    req(1'b0, 30'h5, 4'h0, 32'd0);
    idle(LAT + 2);
    check("lanes_rd", rd_at(br), 32'hAA22CC44);

    // Outstanding limit: third accept lands in the cycle of the first ack.
    ba = acc_log.size(); bk = ack_log.size(); br = rd_log.size();
    req(1'b0, 30'h5, 4'h0, 32'd0);
    req(1'b0, 30'h10, 4'h0, 32'd0);
    req(1'b0, 30'h11, 4'h0, 32'd0);
    req(1'b0, 30'h5, 4'h0, 32'd0);
    idle(LAT + 2);
    check("lim_acks", 32'(ack_log.size() - bk), 32'd4);
    check("lim_acc1", 32'(acc_at(ba + 1)), 32'(acc_at(ba) + 1));
    check("lim_acc3_at_ack1", 32'(acc_at(ba + 2)), 32'(ack_at(bk)));
    check("lim_ack1_lat", 32'(ack_at(bk)), 32'(acc_at(ba) + LAT));
    check("lim_ack4_lat", 32'(ack_at(bk + 3)), 32'(acc_at(ba + 3) + LAT));
    check("lim_rd1", rd_at(br + 1), 32'hDEADBEEF);
    check("lim_rd2", rd_at(br + 2), 32'h12345678);

    // Stall injection window.
    ba = acc_log.size(); bk = ack_log.size();
    stb = 1'b1; we = 1'b0; adr = 30'h5; inj = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("inj_no_acc", 32'(acc_log.size() - ba), 32'd0);
    check("inj_no_ack", 32'(ack_log.size() - bk), 32'd0);
    inj = 1'b0;
    rel = cyc_n;
    @(posedge clk);
    #1 stb = 1'b0;
    idle(LAT + 2);
    check("inj_first_acc", 32'(acc_at(ba)), 32'(rel));
    check("inj_ack", 32'(ack_at(bk)), 32'(rel + LAT));

    // Abort: drop the cycle with a write and a read in flight.
    bk = ack_log.size(); br = rd_log.size();
    req(1'b1, 30'h7, 4'hF, 32'h5A5A5A5A);
    req(1'b0, 30'h10, 4'h0, 32'd0);
    cyc = 1'b0;
    @(posedge clk);
    #1 cyc = 1'b1;
    idle(LAT + 2);
    check("abort_no_ack", 32'(ack_log.size() - bk), 32'd0);
    check("abort_outst", 32'(dut.outst_q), 32'd0);
    req(1'b0, 30'h7, 4'h0, 32'd0);
    idle(LAT + 2);
    check("abort_wr_kept", rd_at(br), 32'h5A5A5A5A);

    // Asynchronous reset while an ack is on the bus.
    req(1'b0, 30'h5, 4'h0, 32'd0);
    req(1'b0, 30'h10, 4'h0, 32'd0);
    bk = ack_log.size();
    idle(1);
    #2 check("rst_pre_ack", 32'(ack_o), 32'd1);
    rst = 1'b0;
    #1 check("rst_async_ack", 32'(ack_o), 32'd0);
    check("rst_async_dat", dat_o, 32'd0);
    cyc = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    cyc = 1'b1;
    idle(LAT + 3);
    check("rst_no_late_ack", 32'(ack_log.size() - bk), 32'd0);

    // Randomized traffic over an initialised, aliased window.
    for (int a = 0; a < 32; a++) req(1'b1, 30'(a), 4'hF, $urandom);
    idle(LAT + 2);
    bk = ack_log.size();
    for (int n = 0; n < 400; n++) begin
      cyc = ($urandom_range(15) != 0);
      stb = 1'($urandom_range(1));
      we  = 1'($urandom_range(1));
      adr = {18'($urandom), 7'd0, 5'($urandom)};
      sel = 4'($urandom);
      dat = $urandom;
      inj = ($urandom_range(7) == 0);
      @(posedge clk);
      #1;
    end
    cyc = 1'b1; inj = 1'b0;
    idle(LAT + 2);
    check("rnd_activity", 32'(ack_log.size() > bk + 20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_wbslave_mem.md
Name: mips_wbslave_mem

Overview:
Wishbone pipelined-mode responder that fronts an on-chip word-addressed RAM and answers the core's program and data memory controllers. It accepts one request per cycle while not stalled and commits writes with byte selects. It returns one in-order ack per request, with read data, after a fixed parameterised latency. It bounds the number of outstanding requests with stall and has a stall-injection input so benches can exercise the initiators' stall and wait paths.

Parameters:
ADDR_BITS, 12, word-address bits used; RAM holds 2**ADDR_BITS 32-bit words; higher address bits are ignored, so the RAM aliases.
LATENCY, 1, cycles from accept edge to ack; legal range 1..4.
MAX_OUTST, 2, maximum requests accepted but not yet acked; legal range 1..LATENCY+1.

Ports:
clk  in  1  clock; all logic on its rising edge.
rst  in  1  reset, asynchronous, active-low.
wb_cyc_i  in  1  bus cycle active.
wb_stb_i  in  1  request strobe.
wb_we_i  in  1  1 = write, 0 = read.
wb_adr_i  in  30  word address [31:2].
wb_sel_i  in  4  byte selects for writes; ignored for reads.
wb_dat_i  in  32  write data.
stall_inject_i  in  1  forces wb_stall_o high while asserted (test hook).
wb_stall_o  out  1  request not accepted this cycle.
wb_ack_o  out  1  one-cycle response strobe.
wb_dat_o  out  32  read data, valid while wb_ack_o is high.

Behaviour:
- Accept: accept = wb_cyc_i & wb_stb_i & !wb_stall_o; at most one accept per cycle.
- Stall (combinational): wb_stall_o = stall_inject_i | (outst == MAX_OUTST & !wb_ack_o). A slot freed by an ack in the same cycle can be reused immediately.
- Write: on the accept edge, RAM[wb_adr_i[ADDR_BITS+1:2]] byte lane i <= wb_dat_i lane i for each set wb_sel_i[i]. sel = 0 writes nothing but is still acked.
- Read: the RAM is read synchronously on the accept edge. The value reflects every write accepted earlier, including the immediately preceding cycle.
- Delay line: LATENCY-stage shift register holding {valid, we, rdata}. Stage 0 loads on accept; the last stage drives the outputs.
  - wb_ack_o = last-stage valid. Ack is asserted exactly LATENCY cycles after the accept edge.
  - Acks are in request order and never back-pressured.
  - wb_dat_o = rdata for a read ack, 32'd0 for a write ack, 32'd0 when not acking.
- outst counter, width clog2(MAX_OUTST+1):
  - +1 on accept only; -1 on ack only; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTST and never underflows. Bench asserts this.
- Cycle abort: when wb_cyc_i is low, all delay-line valid bits clear on the next edge and outst goes to 0.
  - No ack is issued for requests aborted this way.
  - Writes already accepted stay committed.
  - Acks are suppressed in any cycle where wb_cyc_i is low.
- Reset (rst low, asynchronous):
  - wb_ack_o = 0, wb_dat_o = 0, outst = 0, all delay-line stages invalid.
  - wb_stall_o then equals stall_inject_i.
  - RAM contents are not reset.
  - Reset asserted mid-transaction discards all outstanding responses; no ack appears after reset release until a new accept.
- stall_inject_i asserted while requests are outstanding: acks continue on schedule; only new accepts are blocked.

Decomposition:
- Shared package: Wishbone widths (WB_ADR_W = 30, WB_DAT_W = 32, WB_SEL_W = 4) and the legal LATENCY and MAX_OUTST limits, with elaboration checks.
- Sub-module mips_wbslave_delay: parameterised valid/we/data shift register with a synchronous flush input and asynchronous active-low reset. The RAM array and byte-lane write stay in the top module.

Test Plan:
- Back-to-back pipelined writes then reads: LATENCY=1, MAX_OUTST=2; write 0xDEADBEEF to adr 0x10 and 0x12345678 to adr 0x11 with sel = 4'hF; then read both. Each request acked 1 cycle later; read acks return 0xDEADBEEF then 0x12345678; stall stays 0 throughout.
- Byte lanes: write 0xAABBCCDD sel 4'hF to adr 5, then 0x11223344 sel 4'b0101, then read adr 5. Read returns 0xAA22CC44.
- Outstanding limit: LATENCY=3, MAX_OUTST=2; strobe 4 reads continuously. Stall rises after 2 accepts; accept 3 occurs only in the cycle of ack 1; exactly 4 acks, in order.
- Stall injection: hold stall_inject_i high for 5 cycles with stb high. No accepts and no acks during the window; the first accept happens the cycle after release; ack follows LATENCY cycles later.
- Abort: LATENCY=3; accept a write (adr 7, 0x5A5A5A5A) and a read; drop wb_cyc_i before either ack. No acks, outst = 0. A later read of adr 7 returns 0x5A5A5A5A.
- Async reset mid-flight: assert rst low between edges with 2 requests outstanding. wb_ack_o = 0 immediately, and no ack appears after release.
